// File: rtl/mm_token_feeder.sv
// Upstream stage of the matching memory: buffers operand tokens, probes MM, fires packets.
// Optional `define MM_TOKEN_FEEDER_STAT_EN adds saturating hit/store/stall counters.
module mm_token_feeder #(
   parameter int DEPTH  = 4,
   parameter int MM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [27:0] in_key,
   input  logic [31:0] in_data,
   input  logic        in_uni,
   output logic [27:0] mm_key,
   output logic [31:0] mm_data0,
   output logic        mm_uni_opr_flg,
   input  logic        mm_mtch_rslt,
   input  logic [31:0] mm_mtch_data,
   input  logic        mm_full,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [27:0] out_key,
   output logic [31:0] out_data0,
   output logic [31:0] out_data1,
   output logic        out_uni,
   output logic        busy
`ifdef MM_TOKEN_FEEDER_STAT_EN
   ,
   output logic [15:0] stat_hit,
   output logic [15:0] stat_store,
   output logic [15:0] stat_stall
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = 61;
   localparam logic [1:0]    LAT_LAST = 2'(MM_LAT - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PROBE    = 2'd1,
      ST_EMIT     = 2'd2,
      ST_FULLWAIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    lat_cnt_q, lat_cnt_d;
   logic [TW-1:0] fifo_mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;
   logic [27:0]   mm_key_q, mm_key_d;
   logic [31:0]   mm_data0_q, mm_data0_d;
   logic          mm_uni_q, mm_uni_d;
   logic          out_valid_q, out_valid_d;
   logic [27:0]   out_key_q, out_key_d;
   logic [31:0]   out_data0_q, out_data0_d;
   logic [31:0]   out_data1_q, out_data1_d;
   logic          out_uni_q, out_uni_d;
   logic          push_s, pop_s, hit_s, store_s;
   logic [TW-1:0] head_s;

   assign head_s = fifo_mem_q[rd_ptr_q];
   assign push_s = in_valid & in_ready_q;

   // FIFO storage; entries are only read while count says they are valid, so no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_q[wr_ptr_q] <= {in_uni, in_key, in_data};
      end
   end

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < DEPTH_C);
   end

   // Token FSM; mm_key/mm_data0 double as the token register for binary tokens
   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      mm_key_d    = mm_key_q;
      mm_data0_d  = mm_data0_q;
      mm_uni_d    = mm_uni_q;
      out_valid_d = out_valid_q;
      out_key_d   = out_key_q;
      out_data0_d = out_data0_q;
      out_data1_d = out_data1_q;
      out_uni_d   = out_uni_q;
      pop_s       = 1'b0;
      hit_s       = 1'b0;
      store_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop_s = 1'b1;
               if (head_s[60]) begin
                  state_d     = ST_EMIT;
                  out_valid_d = 1'b1;
                  out_key_d   = head_s[59:32];
                  out_data0_d = head_s[31:0];
                  out_data1_d = 32'd0;
                  out_uni_d   = 1'b1;
               end else begin
                  state_d    = ST_PROBE;
                  lat_cnt_d  = 2'd0;
                  mm_key_d   = head_s[59:32];
                  mm_data0_d = head_s[31:0];
                  mm_uni_d   = head_s[60];
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PROBE: begin
            lat_cnt_d = lat_cnt_q + 2'd1;
            if (lat_cnt_q == LAT_LAST) begin
               mm_uni_d = 1'b0;
               if (mm_mtch_rslt) begin
                  hit_s       = 1'b1;
                  state_d     = ST_EMIT;
                  out_valid_d = 1'b1;
                  out_key_d   = mm_key_q;
                  out_data0_d = mm_data0_q;
                  out_data1_d = mm_mtch_data;
                  out_uni_d   = 1'b0;
               end else if (!mm_full) begin
                  store_s = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FULLWAIT;
               end
            end else begin
               state_d = ST_PROBE;
            end
         end
         ST_FULLWAIT: begin
            // A partner may have arrived while MM was full, so the token is probed again
            if (!mm_full) begin
               state_d   = ST_PROBE;
               lat_cnt_d = 2'd0;
            end else begin
               state_d = ST_FULLWAIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = ST_EMIT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            mm_uni_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE) || (count_d != '0);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         lat_cnt_q   <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         mm_key_q    <= 28'd0;
         mm_data0_q  <= 32'd0;
         mm_uni_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_key_q   <= 28'd0;
         out_data0_q <= 32'd0;
         out_data1_q <= 32'd0;
         out_uni_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         mm_key_q    <= mm_key_d;
         mm_data0_q  <= mm_data0_d;
         mm_uni_q    <= mm_uni_d;
         out_valid_q <= out_valid_d;
         out_key_q   <= out_key_d;
         out_data0_q <= out_data0_d;
         out_data1_q <= out_data1_d;
         out_uni_q   <= out_uni_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign busy           = busy_q;
   assign mm_key         = mm_key_q;
   assign mm_data0       = mm_data0_q;
   assign mm_uni_opr_flg = mm_uni_q;
   assign out_valid      = out_valid_q;
   assign out_key        = out_key_q;
   assign out_data0      = out_data0_q;
   assign out_data1      = out_data1_q;
   assign out_uni        = out_uni_q;

`ifdef MM_TOKEN_FEEDER_STAT_EN
   logic [15:0] stat_hit_q, stat_store_q, stat_stall_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_hit_q   <= 16'd0;
         stat_store_q <= 16'd0;
         stat_stall_q <= 16'd0;
      end else begin
         stat_hit_q   <= hit_s   ? sat_inc(stat_hit_q)   : stat_hit_q;
         stat_store_q <= store_s ? sat_inc(stat_store_q) : stat_store_q;
         stat_stall_q <= (state_q == ST_FULLWAIT) ? sat_inc(stat_stall_q) : stat_stall_q;
      end
   end

   assign stat_hit   = stat_hit_q;
   assign stat_store = stat_store_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_mm_token_feeder.sv
// Directed self-checking bench for mm_token_feeder (DEPTH=4, MM_LAT=1).
module tb_mm_token_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] in_key;
   logic [31:0] in_data;
   logic        in_uni;
   logic [27:0] mm_key;
   logic [31:0] mm_data0;
   logic        mm_uni_opr_flg;
   logic        mm_mtch_rslt;
   logic [31:0] mm_mtch_data;
   logic        mm_full;
   logic        out_valid;
   logic        out_ready;
   logic [27:0] out_key;
   logic [31:0] out_data0;
   logic [31:0] out_data1;
   logic        out_uni;
   logic        busy;
`ifdef MM_TOKEN_FEEDER_STAT_EN
   logic [15:0] stat_hit, stat_store, stat_stall;
`endif

   int   checks   = 0;
   int   failures = 0;
   logic mm_uni_seen = 1'b0;

   always #5 clk = ~clk;

   mm_token_feeder #(.DEPTH(4), .MM_LAT(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_key         (in_key),
      .in_data        (in_data),
      .in_uni         (in_uni),
      .mm_key         (mm_key),
      .mm_data0       (mm_data0),
      .mm_uni_opr_flg (mm_uni_opr_flg),
      .mm_mtch_rslt   (mm_mtch_rslt),
      .mm_mtch_data   (mm_mtch_data),
      .mm_full        (mm_full),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_key        (out_key),
      .out_data0      (out_data0),
      .out_data1      (out_data1),
      .out_uni        (out_uni),
      .busy           (busy)
`ifdef MM_TOKEN_FEEDER_STAT_EN
      ,
      .stat_hit       (stat_hit),
      .stat_store     (stat_store),
      .stat_stall     (stat_stall)
`endif
   );

   // Sticky flag: MM must never see the unary flag raised
   always @(negedge clk) begin
      if (mm_uni_opr_flg === 1'b1) mm_uni_seen <= 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int guard;
      int got;
      logic wait_ok;

      // 1: reset with in_valid held high
      rst = 1'b0; in_valid = 1'b1; in_key = 28'h0000001; in_data = 32'h0; in_uni = 1'b0;
      mm_mtch_rslt = 1'b0; mm_mtch_data = 32'h0; mm_full = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      chk("rst_in_ready",  64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",      64'(busy), 64'd0);
      chk("rst_out_key",   64'(out_key), 64'd0);
      chk("rst_out_data0", 64'(out_data0), 64'd0);
      chk("rst_out_data1", 64'(out_data1), 64'd0);
      chk("rst_out_uni",   64'(out_uni), 64'd0);
      chk("rst_mm_key",    64'(mm_key), 64'd0);
      chk("rst_mm_data0",  64'(mm_data0), 64'd0);
      chk("rst_mm_uni",    64'(mm_uni_opr_flg), 64'd0);
      in_valid = 1'b0; rst = 1'b1;
      step();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_busy",     64'(busy), 64'd0);

      // 2: binary hit, out_valid on the third edge counting the push edge
      in_key = 28'h0000123; in_data = 32'hA5A5A5A5; in_uni = 1'b0; in_valid = 1'b1;
      mm_mtch_rslt = 1'b1; mm_mtch_data = 32'h11112222;
      step();
      in_valid = 1'b0;
      chk("hit_busy_after_push", 64'(busy), 64'd1);
      chk("hit_no_valid_e1",     64'(out_valid), 64'd0);
      step();
      chk("hit_mm_key",     64'(mm_key), 64'h0000123);
      chk("hit_mm_data0",   64'(mm_data0), 64'hA5A5A5A5);
      chk("hit_no_valid_e2", 64'(out_valid), 64'd0);
      step();
      chk("hit_out_valid", 64'(out_valid), 64'd1);
      chk("hit_out_key",   64'(out_key), 64'h0000123);
      chk("hit_out_data0", 64'(out_data0), 64'hA5A5A5A5);
      chk("hit_out_data1", 64'(out_data1), 64'h11112222);
      chk("hit_out_uni",   64'(out_uni), 64'd0);
      step();
      chk("hit_hold_valid", 64'(out_valid), 64'd1);
      chk("hit_hold_data1", 64'(out_data1), 64'h11112222);
      out_ready = 1'b1;
      step();
      chk("hit_valid_drop", 64'(out_valid), 64'd0);
      chk("hit_busy_done",  64'(busy), 64'd0);
      out_ready = 1'b0; mm_mtch_rslt = 1'b0;

      // 3: miss with MM not full is stored, no packet
      in_key = 28'h0ABCDEF; in_data = 32'hDEADBEEF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("miss_mm_key", 64'(mm_key), 64'h0ABCDEF);
      step();
      chk("miss_busy",      64'(busy), 64'd0);
      chk("miss_no_valid1", 64'(out_valid), 64'd0);
      step();
      chk("miss_no_valid2", 64'(out_valid), 64'd0);
`ifdef MM_TOKEN_FEEDER_STAT_EN
      chk("stat_store", 64'(stat_store), 64'd1);
`endif

      // 4: miss with MM full, five FULLWAIT cycles, then hit on re-probe
      mm_full = 1'b1;
      in_key = 28'h7654321; in_data = 32'h01234567; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("fw_busy",     64'(busy), 64'd1);
      chk("fw_no_valid", 64'(out_valid), 64'd0);
      repeat (4) step();
      chk("fw_still_no_valid", 64'(out_valid), 64'd0);
      chk("fw_mm_key_held",    64'(mm_key), 64'h7654321);
      chk("fw_mm_uni_low",     64'(mm_uni_opr_flg), 64'd0);
      mm_full = 1'b0; mm_mtch_rslt = 1'b1; mm_mtch_data = 32'hCAFEF00D;
      step();
      chk("fw_reprobe_no_valid", 64'(out_valid), 64'd0);
      step();
      chk("fw_out_valid", 64'(out_valid), 64'd1);
      chk("fw_out_key",   64'(out_key), 64'h7654321);
      chk("fw_out_data0", 64'(out_data0), 64'h01234567);
      chk("fw_out_data1", 64'(out_data1), 64'hCAFEF00D);
`ifdef MM_TOKEN_FEEDER_STAT_EN
      chk("stat_stall", 64'(stat_stall), 64'd5);
      chk("stat_hit",   64'(stat_hit), 64'd2);
`endif
      out_ready = 1'b1;
      step();
      chk("fw_valid_drop", 64'(out_valid), 64'd0);
      out_ready = 1'b0; mm_mtch_rslt = 1'b0;

      // 5: DEPTH+1 unary tokens with downstream stalled
      wait_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_key = 28'h0000100 + 28'(i); in_data = 32'h50000000 + 32'(i);
         in_uni = 1'b1; in_valid = 1'b1;
         guard = 0;
         while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
         end
         if (guard >= 20) wait_ok = 1'b0;
         step();
      end
      chk("uni_push_wait", 64'(wait_ok), 64'd1);
      in_key = 28'h00001FF; in_data = 32'hFFFFFFFF;
      chk("uni_full_ready", 64'(in_ready), 64'd0);
      step();
      step();
      chk("uni_full_ready_hold", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid === 1'b1) begin
            chk("uni_out_key",   64'(out_key), 64'(28'h0000100 + 28'(got)));
            chk("uni_out_data0", 64'(out_data0), 64'(32'h50000000 + 32'(got)));
            chk("uni_out_data1", 64'(out_data1), 64'd0);
            chk("uni_out_uni",   64'(out_uni), 64'd1);
            got++;
         end
         step();
      end
      chk("uni_packet_count", 64'(got), 64'd5);
      chk("uni_drained_busy", 64'(busy), 64'd0);
      out_ready = 1'b0;

      // 6: reset during EMIT with tokens still queued
      in_key = 28'h0000ABC; in_data = 32'h0BADF00D; in_uni = 1'b1; in_valid = 1'b1;
      step();
      in_key = 28'h0000DEF; in_uni = 1'b0;
      step();
      step();
      in_valid = 1'b0;
      chk("rst6_emit_valid", 64'(out_valid), 64'd1);
      rst = 1'b0;
      step();
      chk("rst6_out_valid", 64'(out_valid), 64'd0);
      chk("rst6_busy",      64'(busy), 64'd0);
      chk("rst6_in_ready",  64'(in_ready), 64'd0);
      chk("rst6_out_key",   64'(out_key), 64'd0);
      rst = 1'b1;
      step();
      chk("rst6_ready_after", 64'(in_ready), 64'd1);
      chk("rst6_fifo_empty",  64'(busy), 64'd0);
      step();
      chk("rst6_no_pop", 64'(busy), 64'd0);
      repeat (4) step();
      chk("rst6_packet_lost", 64'(out_valid), 64'd0);

      chk("mm_uni_never_set", 64'(mm_uni_seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
